// File: rtl/dmem_arb_pkg.sv
// Shared types for the line data-memory arbiter.
// FSM states, grant owner and default widths.
package dmem_arb_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_LINE_W = 128;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_CRY = 1'b1
    } owner_t;

endpackage

// File: rtl/dmem_arb_fairness.sv
// Winner selection with a bounded CPU streak so the
// crypto engine cannot be starved by a busy CPU.
module dmem_arb_fairness #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cpu_req,
    input  logic cry_req,
    input  logic grant_strobe,
    output logic cry_wins
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] streak_q;
    logic [3:0] streak_d;

    assign cry_wins = cry_req & (~cpu_req | (streak_q == LIMIT));

    // Streak only moves in decision (IDLE) cycles.
    always_comb begin
        streak_d = streak_q;
        if (grant_strobe) begin
            if (!cry_req || cry_wins) begin
                streak_d = '0;
            end else if (cpu_req && (streak_q != LIMIT)) begin
                streak_d = streak_q + 4'd1;
            end
        end
    end

    // Streak register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter/sequencer for the line memory.
// Registers the winning command, watchdogs the access.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int LINE_W       = DEF_LINE_W,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_mem_read,
    input  logic              cpu_mem_write,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [LINE_W-1:0] cpu_write_data,
    output logic [LINE_W-1:0] cpu_read_data,
    output logic              cpu_done,
    input  logic              cry_req,
    input  logic              cry_we,
    input  logic [ADDR_W-1:0] cry_addr,
    input  logic [LINE_W-1:0] cry_wdata,
    output logic [LINE_W-1:0] cry_rdata,
    output logic              cry_done,
    output logic              mem_read_enable,
    output logic              mem_write_enable,
    output logic [ADDR_W-1:0] mem_address,
    output logic [LINE_W-1:0] mem_write_data,
    input  logic [LINE_W-1:0] mem_read_data,
    input  logic              mem_done,
    output logic              err
);

    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

    state_t            state_q,  state_d;
    owner_t            owner_q,  owner_d;
    logic              rd_q,     rd_d;
    logic              wr_q,     wr_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [LINE_W-1:0] wdata_q,  wdata_d;
    logic [LINE_W-1:0] cpu_rd_q, cpu_rd_d;
    logic [LINE_W-1:0] cry_rd_q, cry_rd_d;
    logic              cpu_dn_q, cpu_dn_d;
    logic              cry_dn_q, cry_dn_d;
    logic              err_q,    err_d;
    logic [7:0]        wdog_q,   wdog_d;

    logic              cpu_req;
    logic              cry_wins;
    logic              finish;
    logic [LINE_W-1:0] cap;

    assign cpu_req = cpu_mem_read | cpu_mem_write;

    dmem_arb_fairness #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_fair (
        .clk          (clk),
        .rst_n        (rst_n),
        .cpu_req      (cpu_req),
        .cry_req      (cry_req),
        .grant_strobe (state_q == S_IDLE),
        .cry_wins     (cry_wins)
    );

    // Next-state, command capture and completion routing.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cpu_rd_d = cpu_rd_q;
        cry_rd_d = cry_rd_q;
        cpu_dn_d = 1'b0;
        cry_dn_d = 1'b0;
        err_d    = err_q;
        wdog_d   = wdog_q;
        finish   = 1'b0;
        cap      = '0;
        unique case (state_q)
            S_IDLE: begin
                if (cpu_req || cry_req) begin
                    state_d = S_BUSY;
                    wdog_d  = '0;
                    if (cry_wins) begin
                        owner_d = OWN_CRY;
                        rd_d    = ~cry_we;
                        wr_d    = cry_we;
                        addr_d  = cry_addr;
                        wdata_d = cry_wdata;
                    end else begin
                        // Read+write together is issued as a write.
                        owner_d = OWN_CPU;
                        rd_d    = cpu_mem_read & ~cpu_mem_write;
                        wr_d    = cpu_mem_write;
                        addr_d  = cpu_address;
                        wdata_d = cpu_write_data;
                    end
                end
            end
            S_BUSY: begin
                if (mem_done) begin
                    cap    = mem_read_data;
                    finish = 1'b1;
                end else if (wdog_q == WD_LAST) begin
                    err_d  = 1'b1;
                    finish = 1'b1;
                end else begin
                    wdog_d = wdog_q + 8'd1;
                end
                if (finish) begin
                    state_d = S_DONE;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    if (owner_q == OWN_CRY) begin
                        cry_rd_d = cap;
                        cry_dn_d = 1'b1;
                    end else begin
                        cpu_rd_d = cap;
                        cpu_dn_d = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                rd_d    = 1'b0;
                wr_d    = 1'b0;
            end
        endcase
    end

    // All state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            owner_q  <= OWN_CPU;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cpu_rd_q <= '0;
            cry_rd_q <= '0;
            cpu_dn_q <= 1'b0;
            cry_dn_q <= 1'b0;
            err_q    <= 1'b0;
            wdog_q   <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cpu_rd_q <= cpu_rd_d;
            cry_rd_q <= cry_rd_d;
            cpu_dn_q <= cpu_dn_d;
            cry_dn_q <= cry_dn_d;
            err_q    <= err_d;
            wdog_q   <= wdog_d;
        end
    end

    assign mem_read_enable  = rd_q;
    assign mem_write_enable = wr_q;
    assign mem_address      = addr_q;
    assign mem_write_data   = wdata_q;
    assign cpu_read_data    = cpu_rd_q;
    assign cry_rdata        = cry_rd_q;
    assign cpu_done         = cpu_dn_q;
    assign cry_done         = cry_dn_q;
    assign err              = err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a completion
// scoreboard and a programmable-latency memory model.
module tb_dmem_arbiter;

    typedef struct packed {
        logic         cry;
        logic [127:0] data;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         cpu_mem_read, cpu_mem_write;
    logic [31:0]  cpu_address;
    logic [127:0] cpu_write_data, cpu_read_data;
    logic         cpu_done;
    logic         cry_req, cry_we;
    logic [31:0]  cry_addr;
    logic [127:0] cry_wdata, cry_rdata;
    logic         cry_done;
    logic         mem_read_enable, mem_write_enable;
    logic [31:0]  mem_address;
    logic [127:0] mem_write_data, mem_read_data;
    logic         mem_done;
    logic         err;

    int   n_cmp = 0;
    int   n_err = 0;
    int   done_total = 0;
    int   lat = 1;
    int   bcnt = 0;
    exp_t sb[$];

    dmem_arbiter #(
        .ADDR_W       (32),
        .LINE_W       (128),
        .STARVE_LIMIT (4),
        .TIMEOUT      (8)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cpu_mem_read     (cpu_mem_read),
        .cpu_mem_write    (cpu_mem_write),
        .cpu_address      (cpu_address),
        .cpu_write_data   (cpu_write_data),
        .cpu_read_data    (cpu_read_data),
        .cpu_done         (cpu_done),
        .cry_req          (cry_req),
        .cry_we           (cry_we),
        .cry_addr         (cry_addr),
        .cry_wdata        (cry_wdata),
        .cry_rdata        (cry_rdata),
        .cry_done         (cry_done),
        .mem_read_enable  (mem_read_enable),
        .mem_write_enable (mem_write_enable),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_read_data    (mem_read_data),
        .mem_done         (mem_done),
        .err              (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(string tag, logic [127:0] obs,
                       logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    // Memory model: answers after lat BUSY cycles; lat=0 never.
    always @(negedge clk) begin
        if (mem_read_enable || mem_write_enable) begin
            bcnt = bcnt + 1;
            mem_done = (lat != 0) && (bcnt == lat);
        end else begin
            bcnt = 0;
            mem_done = 1'b0;
        end
    end

    // Scoreboard: every done pulse is matched to the queue head.
    always @(negedge clk) begin
        if (rst_n && (cpu_done || cry_done)) begin
            exp_t e;
            done_total = done_total + 1;
            chk("one_done", {127'd0, cpu_done ^ cry_done}, 128'd1);
            if (sb.size() == 0) begin
                chk("sb_unexpected", {127'd0, cry_done}, 128'hx);
            end else begin
                e = sb.pop_front();
                chk("sb_owner", {127'd0, cry_done}, {127'd0, e.cry});
                chk("sb_data", cry_done ? cry_rdata : cpu_read_data,
                    e.data);
            end
        end
    end

    task automatic wait_dones(int target);
        int k;
        k = 0;
        while (done_total < target && k < 200) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("done_wait", {127'd0, done_total >= target}, 128'd1);
        @(negedge clk);
        #1;
    endtask

    task automatic issue_cpu(logic rd, logic wr, logic [31:0] a,
                             logic [127:0] d);
        cpu_mem_read   = rd;
        cpu_mem_write  = wr;
        cpu_address    = a;
        cpu_write_data = d;
        @(posedge clk);
        #1;
        cpu_mem_read  = 1'b0;
        cpu_mem_write = 1'b0;
    endtask

    task automatic issue_cry(logic we, logic [31:0] a,
                             logic [127:0] d);
        cry_req   = 1'b1;
        cry_we    = we;
        cry_addr  = a;
        cry_wdata = d;
        @(posedge clk);
        #1;
        cry_req = 1'b0;
    endtask

    initial begin
        logic [127:0] line;
        int rd_cyc, wr_cyc, cdn, ydn, tgt;
        cpu_mem_read = 0; cpu_mem_write = 0;
        cpu_address = 0; cpu_write_data = 0;
        cry_req = 0; cry_we = 0; cry_addr = 0; cry_wdata = 0;
        mem_read_data = 0; mem_done = 0;
        rst_n = 1'b0;
        #12;
        chk("rst_rd_en", {127'd0, mem_read_enable}, 128'd0);
        chk("rst_wr_en", {127'd0, mem_write_enable}, 128'd0);
        chk("rst_cpu_done", {127'd0, cpu_done}, 128'd0);
        chk("rst_cry_done", {127'd0, cry_done}, 128'd0);
        chk("rst_addr", {96'd0, mem_address}, 128'd0);
        chk("rst_wdata", mem_write_data, 128'd0);
        chk("rst_cpu_rdata", cpu_read_data, 128'd0);
        chk("rst_cry_rdata", cry_rdata, 128'd0);
        chk("rst_err", {127'd0, err}, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;

        // CPU read, 3 BUSY cycles.
        line = {16{8'hA5}};
        mem_read_data = line;
        lat = 3;
        sb.push_back('{cry: 1'b0, data: line});
        issue_cpu(1'b1, 1'b0, 32'h10, 128'd0);
        rd_cyc = 0; cdn = 0; ydn = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_read_enable) begin
                rd_cyc++;
                chk("t1_addr", {96'd0, mem_address}, 128'h10);
            end
            cdn += int'(cpu_done);
            ydn += int'(cry_done);
        end
        chk("t1_rd_cycles", 128'(rd_cyc), 128'd3);
        chk("t1_cpu_done_cnt", 128'(cdn), 128'd1);
        chk("t1_cry_done_cnt", 128'(ydn), 128'd0);
        @(negedge clk);
        #1;

        // Both held, 1-cycle memory: C C C C Y C C C C Y.
        line = 128'h0123_4567_89AB_CDEF_0F1E_2D3C_4B5A_6978;
        mem_read_data = line;
        lat = 1;
        for (int i = 0; i < 10; i++) begin
            sb.push_back('{cry: (i % 5 == 4), data: line});
        end
        tgt = done_total + 10;
        cpu_address = 32'h100;
        cry_addr = 32'h200;
        cry_we = 1'b0;
        cpu_mem_read = 1'b1;
        cry_req = 1'b1;
        for (int k = 0; k < 100 && done_total < tgt; k++) begin
            @(negedge clk);
            #1;
        end
        cpu_mem_read = 1'b0;
        cry_req = 1'b0;
        wait_dones(tgt);

        // Read+write together is a write only.
        line = {4{32'hDEAD_BEEF}};
        mem_read_data = line;
        lat = 2;
        sb.push_back('{cry: 1'b0, data: line});
        tgt = done_total + 1;
        issue_cpu(1'b1, 1'b1, 32'h40, 128'h1);
        @(negedge clk);
        chk("t3_wr_en", {127'd0, mem_write_enable}, 128'd1);
        chk("t3_rd_en", {127'd0, mem_read_enable}, 128'd0);
        chk("t3_wdata", mem_write_data, 128'h1);
        wait_dones(tgt);

        // Crypto write, memory never answers: timeout.
        lat = 0;
        sb.push_back('{cry: 1'b1, data: 128'd0});
        tgt = done_total + 1;
        issue_cry(1'b1, 32'h80, {8{16'h5A5A}});
        wr_cyc = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            wr_cyc += int'(mem_write_enable);
        end
        chk("t4_busy_cycles", 128'(wr_cyc), 128'd8);
        chk("t4_err", {127'd0, err}, 128'd1);
        chk("t4_done_seen", {127'd0, done_total >= tgt}, 128'd1);
        repeat (3) @(negedge clk);
        chk("t4_err_sticky", {127'd0, err}, 128'd1);
        #1;

        // Reset in the 2nd BUSY cycle.
        issue_cpu(1'b1, 1'b0, 32'h20, 128'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rd_en", {127'd0, mem_read_enable}, 128'd0);
        chk("t5_done", {126'd0, cpu_done, cry_done}, 128'd0);
        chk("t5_err", {127'd0, err}, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        line = {16{8'h3C}};
        mem_read_data = line;
        lat = 1;
        sb.push_back('{cry: 1'b0, data: line});
        tgt = done_total + 1;
        issue_cpu(1'b1, 1'b0, 32'h30, 128'd0);
        wait_dones(tgt);

        // mem_done coincides with watchdog limit.
        line = {16{8'hC3}};
        mem_read_data = line;
        lat = 8;
        sb.push_back('{cry: 1'b0, data: line});
        tgt = done_total + 1;
        issue_cpu(1'b1, 1'b0, 32'h50, 128'd0);
        wait_dones(tgt);
        chk("t6_err", {127'd0, err}, 128'd0);

        chk("sb_empty", 128'(sb.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
